slv_reg_resp: RTL and testbench

SLV_REG_RESP -- requirements
Module: slv_reg_resp

---
 rtl/slv_reg_resp_pkg.sv | 29 ++
 rtl/slv_reg_array.sv | 32 +++
 rtl/slv_reg_resp.sv | 120 ++++++++++++
 tb/tb_slv_reg_resp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/slv_reg_resp_pkg.sv
// Shared bus package: FSM state encoding, widths and wait-count limits
// used by the slave register responder and its storage array.
package slv_reg_resp_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 4;
  localparam int CNT_W    = 5;
  localparam int NUM_REGS = 16;

  // Wait counter is sized to hold the largest legal WAIT_CYCLES-1.
  localparam int MAX_WAIT_CYCLES = 7;
  localparam int WCNT_W          = 3;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  // Value loaded into the wait counter when a request is accepted.
  function automatic logic [WCNT_W-1:0] waitLoad(input int waitCycles);
    if (waitCycles > 0) begin
      return WCNT_W'(waitCycles - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/slv_reg_array.sv
// 16 x 4 storage array with one synchronous write port and one
// combinational read port; reset loads every entry with RESET_VAL.
module slv_reg_array
  import slv_reg_resp_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Reset has priority, so a write requested in the reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/slv_reg_resp.sv
// Slave register responder: each accepted request is a swap on one of
// 16 registers, answered after WAIT_CYCLES wait states with a one-cycle
// ready strobe. Dropping valid before completion aborts and sets a
// sticky error flag.
module slv_reg_resp
  import slv_reg_resp_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [3:0]  RESET_VAL   = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        slv_valid,
  input  logic [3:0]  slv_addr,
  input  logic [3:0]  slv_wdata,
  output logic [3:0]  slv_rdata,
  output logic        slv_ready,
  output logic [4:0]  bus_out,
  output logic        err
);

  localparam logic [WCNT_W-1:0] WAIT_INIT = waitLoad(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    txnCnt_q, txnCnt_d;
  logic                err_q, err_d;
  logic                writeEn;
  logic [DATA_W-1:0]   oldData;
  logic                inResp;

  // Next-state logic: accept in IDLE, count wait states, complete or abort.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    txnCnt_d  = txnCnt_q;
    err_d     = err_q;
    writeEn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slv_valid) begin
          addr_d  = slv_addr;
          wdata_d = slv_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            waitCnt_d = WAIT_INIT;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!slv_valid) begin
          state_d   = ST_IDLE;
          waitCnt_d = '0;
          err_d     = 1'b1;
        end else if (waitCnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (slv_valid) begin
          writeEn  = 1'b1;
          txnCnt_d = txnCnt_q + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txnCnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txnCnt_q  <= txnCnt_d;
      err_q     <= err_d;
    end
  end

  slv_reg_array #(
    .RESET_VAL (RESET_VAL)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (writeEn),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (oldData)
  );

  // Ready and read data are masked while reset is asserted.
  assign inResp    = (state_q == ST_RESP) && !reset;
  assign slv_ready = inResp;
  assign slv_rdata = inResp ? oldData : 4'h0;
  assign bus_out   = txnCnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_slv_reg_resp.sv
// Bench for slv_reg_resp: instance A uses WAIT_CYCLES=2 with default
// reset value, instance B uses WAIT_CYCLES=0 with RESET_VAL=4'h9.
// A behavioural model of the register file, completion count and
// error flag predicts every observed value.
module tb_slv_reg_resp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetA, validA, readyA, errA;
  logic [3:0] addrA, wdataA, rdataA;
  logic [4:0] busA;
  logic       resetB, validB, readyB, errB;
  logic [3:0] addrB, wdataB, rdataB;
  logic [4:0] busB;

  slv_reg_resp #(.WAIT_CYCLES(2), .RESET_VAL(4'h0)) dutA (
    .clock(clock), .reset(resetA), .slv_valid(validA), .slv_addr(addrA),
    .slv_wdata(wdataA), .slv_rdata(rdataA), .slv_ready(readyA),
    .bus_out(busA), .err(errA)
  );

  slv_reg_resp #(.WAIT_CYCLES(0), .RESET_VAL(4'h9)) dutB (
    .clock(clock), .reset(resetB), .slv_valid(validB), .slv_addr(addrB),
    .slv_wdata(wdataB), .slv_rdata(rdataB), .slv_ready(readyB),
    .bus_out(busB), .err(errB)
  );

  int numAsserts = 0;
  int numFails   = 0;

  // Model state: per instance register contents, completion count, error.
  logic [3:0] model [2][16];
  logic [4:0] cntM  [2];
  logic       errM  [2];

  function automatic int waitOf(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  function automatic logic [3:0] resetValOf(input int w);
    return (w == 0) ? 4'h0 : 4'h9;
  endfunction

  function automatic logic readyOf(input int w);
    return (w == 0) ? readyA : readyB;
  endfunction

  function automatic logic [3:0] rdataOf(input int w);
    return (w == 0) ? rdataA : rdataB;
  endfunction

  function automatic logic [4:0] busOf(input int w);
    return (w == 0) ? busA : busB;
  endfunction

  function automatic logic errOf(input int w);
    return (w == 0) ? errA : errB;
  endfunction

  // Immediate-assertion comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numAsserts++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int w, input logic v, input logic [3:0] a, input logic [3:0] d);
    if (w == 0) begin
      validA = v; addrA = a; wdataA = d;
    end else begin
      validB = v; addrB = a; wdataB = d;
    end
  endtask

  task automatic resetModel(input int w);
    for (int i = 0; i < 16; i++) model[w][i] = resetValOf(w);
    cntM[w] = '0;
    errM[w] = 1'b0;
  endtask

  // Idle cycles with valid low: no strobe, status matches the model.
  task automatic idle(input int w, input int n);
    applyStimulus(w, 1'b0, 4'($urandom), 4'($urandom));
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      checkOutput("idle_ready", readyOf(w), 0);
      checkOutput("idle_rdata", rdataOf(w), 0);
      checkOutput("idle_bus", busOf(w), cntM[w]);
      checkOutput("idle_err", errOf(w), errM[w]);
      @(posedge clock); #1;
    end
  endtask

  // One complete swap, starting in an IDLE cycle. Address and data are
  // scrambled after the request cycle; the captured values must win.
  task automatic swap(input int w, input logic [3:0] a, input logic [3:0] d);
    applyStimulus(w, 1'b1, a, d);
    for (int k = 0; k <= waitOf(w); k++) begin
      @(negedge clock);
      checkOutput("pre_ready", readyOf(w), 0);
      checkOutput("pre_rdata", rdataOf(w), 0);
      if (k == 0) begin
        checkOutput("start_bus", busOf(w), cntM[w]);
        checkOutput("start_err", errOf(w), errM[w]);
      end
      @(posedge clock); #1;
      applyStimulus(w, 1'b1, 4'($urandom), 4'($urandom));
    end
    @(negedge clock);
    checkOutput("resp_ready", readyOf(w), 1);
    checkOutput("resp_rdata", rdataOf(w), model[w][a]);
    @(posedge clock); #1;
    model[w][a] = d;
    cntM[w]     = cntM[w] + 5'd1;
  endtask

  // Request, then drop valid k cycles later (in WAIT or RESP).
  task automatic abortAfter(input int w, input logic [3:0] a, input logic [3:0] d, input int k);
    applyStimulus(w, 1'b1, a, d);
    for (int c = 0; c < k; c++) begin
      @(negedge clock);
      checkOutput("abort_pre_ready", readyOf(w), 0);
      @(posedge clock); #1;
    end
    applyStimulus(w, 1'b0, 4'($urandom), 4'($urandom));
    @(negedge clock);
    if (k <= waitOf(w)) checkOutput("abort_ready", readyOf(w), 0);
    @(posedge clock); #1;
    errM[w] = 1'b1;
    idle(w, 2);
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1;
    applyStimulus(0, 1'b0, 4'h0, 4'h0);
    applyStimulus(1, 1'b0, 4'h0, 4'h0);
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("rst_readyA", readyA, 0);
    checkOutput("rst_rdataA", rdataA, 0);
    checkOutput("rst_busA", busA, 0);
    checkOutput("rst_errA", errA, 0);
    checkOutput("rst_readyB", readyB, 0);
    checkOutput("rst_busB", busB, 0);
    @(posedge clock); #1;
    resetA = 1'b0; resetB = 1'b0;
    resetModel(0);
    resetModel(1);

    // Instance A: single swap then back-to-back swap on register 12.
    swap(0, 4'hc, 4'h5);
    swap(0, 4'hc, 4'ha);
    idle(0, 1);

    // Abort in WAIT: register 1 must stay untouched.
    abortAfter(0, 4'h1, 4'hf, 1);
    swap(0, 4'h1, 4'($urandom));

    // Randomised swaps against the model.
    repeat (20) swap(0, 4'($urandom), 4'($urandom));

    // Reset asserted during the RESP cycle.
    applyStimulus(0, 1'b1, 4'hc, 4'h7);
    for (int k = 0; k <= waitOf(0); k++) begin
      @(posedge clock); #1;
    end
    resetA = 1'b1;
    @(negedge clock);
    checkOutput("rstresp_ready", readyA, 0);
    checkOutput("rstresp_rdata", rdataA, 0);
    @(posedge clock); #1;
    resetA = 1'b0;
    resetModel(0);
    idle(0, 1);

    // Read back every register (reset value), then complete 32 in total.
    for (int i = 0; i < 16; i++) swap(0, 4'(i), 4'($urandom));
    repeat (16) swap(0, 4'($urandom), 4'($urandom));
    idle(0, 1);
    checkOutput("bus_wrap", busA, 0);

    // Instance B: zero-wait swaps with valid held, every two cycles.
    swap(1, 4'h3, 4'h6);
    repeat (6) swap(1, 4'($urandom), 4'($urandom));
    abortAfter(1, 4'h3, 4'h2, 1);
    swap(1, 4'h3, 4'($urandom));
    idle(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the test");
    $fatal(1, "[TB] watchdog");
  end

endmodule
